// File: rtl/vgafb_scangen.sv
// Raster scan generator for the VGA framebuffer.
// Walks a programmable (h,v) raster, pulls pixels from the feed over a
// valid/ack handshake, and emits one {vsync,hsync,blank_n,RGB888} word per
// step into the sys->vga clock-crossing FIFO. Timing, sync polarity and pixel
// format live in shadow registers. Changes are committed atomically at frame
// end, or continuously while the generator is disabled.
module vgafb_scangen #(
  parameter int CW = 11,
  parameter int PW = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          enable,
  input  logic [CW-1:0] hres,
  input  logic [CW-1:0] hsync_start,
  input  logic [CW-1:0] hsync_end,
  input  logic [CW-1:0] hscan,
  input  logic [CW-1:0] vres,
  input  logic [CW-1:0] vsync_start,
  input  logic [CW-1:0] vsync_end,
  input  logic [CW-1:0] vscan,
  input  logic          hsync_pol,
  input  logic          vsync_pol,
  input  logic [1:0]    fmt,
  input  logic          cfg_load,
  output logic          cfg_pending,
  input  logic          pix_valid,
  input  logic [PW-1:0] pix_data,
  output logic          pix_ack,
  input  logic          out_full,
  output logic          out_we,
  output logic [26:0]   out_data,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          frame_start,
  output logic          vblank_start
);

  typedef struct packed {
    logic [CW-1:0] hres;
    logic [CW-1:0] hsync_start;
    logic [CW-1:0] hsync_end;
    logic [CW-1:0] hscan;
    logic [CW-1:0] vres;
    logic [CW-1:0] vsync_start;
    logic [CW-1:0] vsync_end;
    logic [CW-1:0] vscan;
    logic          hsync_pol;
    logic          vsync_pol;
    logic [1:0]    fmt;
  } cfg_t;

  cfg_t       cfg_in;
  cfg_t       shd;
  logic       active;
  logic       step;
  logic       h_last;
  logic       v_last;
  logic       hs_on;
  logic       vs_on;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  // Live configuration inputs gathered into one word for shadow loading.
  assign cfg_in = '{hres: hres, hsync_start: hsync_start, hsync_end: hsync_end,
                    hscan: hscan, vres: vres, vsync_start: vsync_start,
                    vsync_end: vsync_end, vscan: vscan, hsync_pol: hsync_pol,
                    vsync_pol: vsync_pol, fmt: fmt};

  // Raster position qualifiers and the handshake; all zero-latency.
  always_comb begin
    active  = (hpos < shd.hres) && (vpos < shd.vres);
    step    = enable && !sys_rst && !out_full && (!active || pix_valid);
    out_we  = step;
    pix_ack = step && active;
    h_last  = (hpos == shd.hscan);
    v_last  = (vpos == shd.vscan);
    // An empty or inverted window (end <= start) can never match.
    hs_on   = (hpos >= shd.hsync_start) && (hpos < shd.hsync_end);
    vs_on   = (vpos >= shd.vsync_start) && (vpos < shd.vsync_end);
  end

  // Pixel format expansion to RGB888; 565 channels replicate their MSBs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    r = '0;
    g = '0;
    b = '0;
    case (shd.fmt)
      2'd0: begin
        r = {pix_data[15:11], pix_data[15:13]};
        g = {pix_data[10:5],  pix_data[10:9]};
        b = {pix_data[4:0],   pix_data[4:2]};
      end
      2'd1: begin
        r = pix_data[23:16];
        g = pix_data[15:8];
        b = pix_data[7:0];
      end
      default: begin
        r = pix_data[7:0];
        g = pix_data[7:0];
        b = pix_data[7:0];
      end
    endcase
  end

  // Output word for the current position; blanked words carry black.
  always_comb begin
    out_data = {vs_on ? shd.vsync_pol : ~shd.vsync_pol,
                hs_on ? shd.hsync_pol : ~shd.hsync_pol,
                active,
                active ? {r, g, b} : 24'd0};
  end

  // Raster counters, frame-atomic shadow commit and event pulses.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (sys_rst) begin
      hpos         <= '0;
      vpos         <= '0;
      shd          <= '0;
      cfg_pending  <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else if (!enable) begin
      hpos         <= '0;
      vpos         <= '0;
      shd          <= cfg_in;
      cfg_pending  <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      frame_start  <= step && (hpos == '0) && (vpos == '0);
      vblank_start <= step && (hpos == '0) && (vpos == shd.vres);
      if (cfg_load) cfg_pending <= 1'b1;
      if (step) begin
        if (h_last) begin
          hpos <= '0;
          vpos <= v_last ? '0 : vpos + 1'b1;
          // A request arriving on the commit step itself stays pending.
          if (v_last && cfg_pending) begin
            shd         <= cfg_in;
            cfg_pending <= cfg_load;
          end
        end else begin
          hpos <= hpos + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vgafb_scangen.sv
// Directed bench for vgafb_scangen: reset, full frames, pixel formats,
// back-pressure stalls, frame-atomic reload, sync polarity, mid-frame reset.
module tb_vgafb_scangen;

  localparam int CW = 11;
  localparam int PW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          enable;
  logic [CW-1:0] hres, hsync_start, hsync_end, hscan;
  logic [CW-1:0] vres, vsync_start, vsync_end, vscan;
  logic          hsync_pol, vsync_pol;
  logic [1:0]    fmt;
  logic          cfg_load;
  logic          cfg_pending;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic          pix_ack;
  logic          out_full;
  logic          out_we;
  logic [26:0]   out_data;
  logic [CW-1:0] hpos, vpos;
  logic          frame_start, vblank_start;

  int vectors     = 0;
  int miscompares = 0;

  // Per-frame tallies filled by run_frame.
  int cnt_we, cnt_ack, cnt_hs1, cnt_vs1, cnt_fs, cnt_vb, fs_idx, vb_idx;

  vgafb_scangen #(.CW(CW), .PW(PW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .hres(hres), .hsync_start(hsync_start), .hsync_end(hsync_end), .hscan(hscan),
    .vres(vres), .vsync_start(vsync_start), .vsync_end(vsync_end), .vscan(vscan),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .fmt(fmt),
    .cfg_load(cfg_load), .cfg_pending(cfg_pending),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ack(pix_ack),
    .out_full(out_full), .out_we(out_we), .out_data(out_data),
    .hpos(hpos), .vpos(vpos),
    .frame_start(frame_start), .vblank_start(vblank_start)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cycle();
    @(posedge sys_clk);
    #2;
  endtask

  // Run n steps from (0,0) with feed valid and no back-pressure, checking
  // position, blanking and ack each cycle and tallying sync levels/pulses.
  task automatic run_frame(input int n, input int hr, input int vr, input int hl, input int vl);
    int eh, ev;
    logic act;
    eh = 0; ev = 0;
    cnt_we = 0; cnt_ack = 0; cnt_hs1 = 0; cnt_vs1 = 0; cnt_fs = 0; cnt_vb = 0;
    fs_idx = -1; vb_idx = -1;
    for (int i = 0; i < n; i++) begin
      #1;
      act = (eh < hr) && (ev < vr);
      check("frm_pos", {hpos, vpos}, {CW'(eh), CW'(ev)});
      check("frm_blank_n", out_data[24], act);
      check("frm_ack", pix_ack, act);
      cnt_we  += int'(out_we);
      cnt_ack += int'(pix_ack);
      if (out_we && out_data[25]) cnt_hs1++;
      if (out_we && out_data[26]) cnt_vs1++;
      if (frame_start) begin cnt_fs++; if (fs_idx < 0) fs_idx = i; end
      if (vblank_start) begin cnt_vb++; if (vb_idx < 0) vb_idx = i; end
      if (eh == hl) begin
        eh = 0;
        ev = (ev == vl) ? 0 : ev + 1;
      end else begin
        eh++;
      end
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   acks;

    sys_rst = 1'b1; enable = 1'b1;
    hres = 4; hsync_start = 5; hsync_end = 6; hscan = 7;
    vres = 2; vsync_start = 3; vsync_end = 4; vscan = 5;
    hsync_pol = 1'b0; vsync_pol = 1'b0; fmt = 2'd1;
    cfg_load = 1'b0; pix_valid = 1'b1; pix_data = 32'h00123456; out_full = 1'b0;

    // Reset state; the feed is offered but nothing may be written.
    cycle(); cycle(); #1;
    check("rst_pos", {hpos, vpos}, 22'd0);
    check("rst_we", out_we, 1'b0);
    check("rst_ack", pix_ack, 1'b0);
    check("rst_pending", cfg_pending, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_vb", vblank_start, 1'b0);

    // Disabled: no writes while shadows follow the inputs.
    sys_rst = 1'b0; enable = 1'b0; #1;
    check("dis_we", out_we, 1'b0);
    cycle();
    enable = 1'b1; #1;
    check("en_first_word", out_data, {1'b1, 1'b1, 1'b1, 24'h123456});
    #1;

    // Full frame under timing A: 48 writes, 8 acks, hsync low at h=5 only.
    run_frame(48, 4, 2, 7, 5);
    check("a_writes", cnt_we, 48);
    check("a_acks", cnt_ack, 8);
    check("a_hs_high", cnt_hs1, 42);
    check("a_vs_high", cnt_vs1, 40);
    check("a_fs_count", cnt_fs, 1);
    check("a_fs_idx", fs_idx, 1);
    check("a_vb_count", cnt_vb, 1);
    check("a_vb_idx", vb_idx, 17);
    #1;
    check("a_wrap_pos", {hpos, vpos}, 22'd0);
    check("a_fs_after_wrap", frame_start, 1'b0);

    // Pixel formats (shadowed, so reload through enable=0).
    enable = 1'b0; fmt = 2'd0; pix_data = 32'h0000F800;
    cycle();
    enable = 1'b1; #1;
    check("fmt0_red", out_data[23:0], 24'hFF0000);
    pix_data = 32'h000007E0; #1;
    check("fmt0_green", out_data[23:0], 24'h00FF00);
    pix_data = 32'h00008410; #1;
    check("fmt0_mid", out_data[23:0], 24'h848284);
    cycle(); #1;
    check("en_rise_fs", frame_start, 1'b1);
    check("en_rise_h1", hpos, 11'd1);

    enable = 1'b0; fmt = 2'd1; pix_data = 32'h00123456;
    cycle();
    enable = 1'b1; #1;
    check("fmt1", out_data[23:0], 24'h123456);

    enable = 1'b0; fmt = 2'd2; pix_data = 32'h12345680;
    cycle();
    enable = 1'b1; #1;
    check("fmt2", out_data[23:0], 24'h808080);
    fmt = 2'd1; #1;
    check("fmt_shadowed", out_data[23:0], 24'h808080);

    enable = 1'b0; fmt = 2'd3;
    cycle();
    enable = 1'b1; #1;
    check("fmt3", out_data[23:0], 24'h808080);

    // Back-pressure: out_full then pix_valid low, both in the active area.
    enable = 1'b0; fmt = 2'd1; pix_data = 32'h00C00000;
    cycle();
    enable = 1'b1; #1;
    check("st_p0", {pix_ack, out_data[23:0]}, {1'b1, 24'hC00000});
    cycle();
    pix_data = 32'h00C00001; #1;
    check("st_p1", {hpos, out_data[23:0]}, {11'd1, 24'hC00001});
    cycle();
    pix_data = 32'h00C00002; out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_full", {out_we, pix_ack, hpos}, {2'b00, 11'd2});
      cycle();
    end
    out_full = 1'b0; pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_novalid", {out_we, pix_ack, hpos}, {2'b00, 11'd2});
      cycle();
    end
    pix_valid = 1'b1; #1;
    check("st_resume", {out_we, pix_ack, hpos, out_data[23:0]}, {2'b11, 11'd2, 24'hC00002});
    cycle();
    pix_data = 32'h00C00003; #1;
    check("st_next", {hpos, out_data[23:0]}, {11'd3, 24'hC00003});

    // Frame-atomic reload: hres 4 -> 6 requested at (3,0).
    hres = 6; cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0; #1;
    check("cfg_pending_set", cfg_pending, 1'b1);
    found = 1'b0; acks = 0;
    for (int k = 0; k < 200; k++) begin
      if (hpos == 11'd7 && vpos == 11'd5) begin found = 1'b1; break; end
      acks += int'(pix_ack);
      cycle(); #1;
    end
    check("cfg_reach_end", found, 1'b1);
    check("cfg_old_acks", acks, 4);
    check("cfg_pending_end", cfg_pending, 1'b1);
    cycle(); #1;
    check("cfg_committed", cfg_pending, 1'b0);
    check("cfg_new_pos", {hpos, vpos}, 22'd0);
    #1;
    run_frame(48, 6, 2, 7, 5);
    check("cfg_new_acks", cnt_ack, 12);
    check("cfg_new_fs_idx", fs_idx, 1);
    check("cfg_new_pending", cfg_pending, 1'b0);

    // Sync polarity high, then an empty hsync window.
    enable = 1'b0; hres = 4; hsync_pol = 1'b1; vsync_pol = 1'b1;
    cycle();
    enable = 1'b1;
    run_frame(48, 4, 2, 7, 5);
    check("pol1_hs_high", cnt_hs1, 6);
    check("pol1_vs_high", cnt_vs1, 8);

    enable = 1'b0; hsync_end = 5;
    cycle();
    enable = 1'b1;
    run_frame(48, 4, 2, 7, 5);
    check("hs_empty_high", cnt_hs1, 0);
    check("hs_empty_vs", cnt_vs1, 8);

    // Mid-frame reset at (3,1).
    enable = 1'b0; hsync_end = 6; hsync_pol = 1'b0; vsync_pol = 1'b0;
    cycle();
    enable = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    #1;
    check("mr_pos_before", {hpos, vpos}, {11'd3, 11'd1});
    sys_rst = 1'b1;
    cycle(); #1;
    check("mr_pos", {hpos, vpos}, 22'd0);
    check("mr_we", {out_we, pix_ack}, 2'b00);
    check("mr_pending", cfg_pending, 1'b0);
    sys_rst = 1'b0; #1;
    // Zeroed shadows: nothing active, sync windows empty, polarity 0 -> level 1.
    check("mr_shadow_word", {out_we, out_data}, {1'b1, 27'h6000000});
    cycle(); #1;
    check("mr_zero_raster_fs", {frame_start, hpos, vpos}, {1'b1, 22'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
